// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-register state encoding and
// default widths reused by every stage register in the pipeline.
package pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PERF_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and saturating stall/flush performance counters.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned             DATA_W    = XLEN,
    parameter int unsigned             PC_W      = XLEN,
    parameter logic [DATA_W-1:0]       RESET_VAL = '0,
    parameter int unsigned             CNT_W     = PERF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    skid_state_t       r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_skid_data;
    logic [PC_W-1:0]   r_skid_pc;

    logic w_out_valid;
    logic w_in_ready;
    logic w_acc;
    logic w_pop;
    logic w_stall;

    // Ready depends only on the state register, never on out_ready_i.
    assign w_out_valid = (r_state != EMPTY);
    assign w_in_ready  = (r_state != FULL);
    assign w_acc       = in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && out_ready_i;
    assign w_stall     = w_out_valid && !out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= EMPTY;
            r_main_data <= RESET_VAL;
            r_main_pc   <= '0;
            r_skid_data <= RESET_VAL;
            r_skid_pc   <= '0;
        end else if (flush_i) begin
            r_state     <= EMPTY;
            r_main_data <= RESET_VAL;
            r_main_pc   <= '0;
            r_skid_data <= RESET_VAL;
            r_skid_pc   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_state     <= ONE;
                        r_main_data <= in_data_i;
                        r_main_pc   <= in_pc_i;
                    end
                end
                ONE: begin
                    if (w_acc && w_pop) begin
                        r_main_data <= in_data_i;
                        r_main_pc   <= in_pc_i;
                    end else if (w_acc) begin
                        r_state     <= FULL;
                        r_skid_data <= in_data_i;
                        r_skid_pc   <= in_pc_i;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state     <= ONE;
                        r_main_data <= r_skid_data;
                        r_main_pc   <= r_skid_pc;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_data_o  = w_out_valid ? r_main_data : RESET_VAL;
    assign out_pc_o    = w_out_valid ? r_main_pc : '0;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_stall),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_i),
        .count_o (flush_cnt_o)
    );

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register that replaces the fixed stall/flush stage register between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data word and its PC across a valid/ready handshake with a two-entry skid buffer, so back-pressure holds the payload instead of zeroing it. Flush inserts a bubble. Saturating stall and flush counters feed the debug/performance view.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (≥1)
- PC_W, 32, PC width in bits
- RESET_VAL, 0, DATA_W-bit value driven on out_data_o when no valid entry is present
- CNT_W, 16, width of each performance counter

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all held entries this cycle
- in_valid_i  in  1  upstream stage offers a payload
- in_ready_o  out  1  stage can accept; a transfer happens when in_valid_i && in_ready_o
- in_data_i  in  DATA_W  upstream payload
- in_pc_i  in  PC_W  PC of the upstream payload
- out_valid_o  out  1  output entry holds a payload
- out_ready_i  in  1  downstream stage consumes; a pop happens when out_valid_o && out_ready_i
- out_data_o  out  DATA_W  output payload, or RESET_VAL when out_valid_o=0
- out_pc_o  out  PC_W  output PC, or 0 when out_valid_o=0
- stall_cnt_o  out  CNT_W  cycles with out_valid_o && !out_ready_i, saturating
- flush_cnt_o  out  CNT_W  cycles with flush_i=1, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds data and PC.
- State register values: EMPTY, ONE, FULL.
  - out_valid_o = (state != EMPTY)
  - in_ready_o = (state != FULL), decoded from the state register only, with no combinational path from out_ready_i
- Transitions, with acc = accept and pop = pop:
  - EMPTY: acc → ONE, main ← input.
  - ONE:
    - acc & pop → ONE, main ← input.
    - acc & !pop → FULL, skid ← input.
    - !acc & pop → EMPTY.
    - Otherwise hold.
  - FULL: in_ready_o=0, so acc cannot occur.
    - pop → ONE, main ← skid.
    - Otherwise hold.
- Flush has priority over everything:
  - Next state is EMPTY; main and skid are cleared to RESET_VAL / 0.
  - A payload offered in the flush cycle is dropped, even if in_ready_o=1.
  - A pop in the flush cycle still counts as consumed downstream.
- Hold rule: while out_valid_o && !out_ready_i, out_data_o and out_pc_o must not change.
- Order: payloads leave in acceptance order; none are lost or duplicated except through flush.
- Counters:
  - Increment by 1 on their condition and stick at 2^CNT_W−1.
  - A flush cycle with a stalled output increments both counters.
- Reset (rst_i=0, asynchronous):
  - state=EMPTY, out_valid_o=0, in_ready_o=1
  - out_data_o=RESET_VAL, out_pc_o=0, both counters 0
  - Reset asserted mid-transfer discards all entries.

## Timing
- Latency: a payload accepted at edge N is visible on out_* after edge N, with out_valid_o=1 in cycle N+1.
- Throughput: 1 payload/cycle when out_ready_i is held high; the skid entry stays empty.
- in_ready_o falls the cycle after the first unpopped accept while ONE (state FULL). It rises the cycle after the pop that drains the skid.
- Flush takes effect at the next edge: out_valid_o=0 and in_ready_o=1 the following cycle.
- Counters update at the same edge as the condition; the value is visible the next cycle.

## Structure
- Shared package pipe_pkg:
  - state typedef (EMPTY/ONE/FULL)
  - default width constants (XLEN=32, PERF_CNT_W=16), reused by the other pipeline stages
- Sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, count_o), instantiated twice.

## Test plan
- Streaming: reset, out_ready_i=1, feed data 0x11..0x18 with PCs 0x0..0x1C on consecutive cycles → same sequence out one cycle later; in_ready_o stays 1; stall_cnt_o=0.
- Back-pressure: accept 0xA1 (PC 0x40), drop out_ready_i for 3 cycles while offering 0xA2 and 0xA3.
  - 0xA2 lands in skid; in_ready_o=0 from the next cycle; 0xA3 is held upstream.
  - out_data_o stays 0xA1 for all 3 cycles; stall_cnt_o=3.
  - On release, output order is 0xA1, 0xA2, 0xA3.
- Flush while FULL, with in_valid_i=1 and data 0xB3 → next cycle out_valid_o=0, out_data_o=RESET_VAL, in_ready_o=1; 0xB3 never appears at the output; flush_cnt_o=1.
- Async reset mid-stall: assert rst_i low between edges while FULL → outputs go to reset values immediately without waiting for a clock edge; after release, the first accept emerges normally.
- Saturation with CNT_W=4: hold a stalled output for 20 cycles → stall_cnt_o reaches 15 and stays at 15.
- Width generality at DATA_W=1 and DATA_W=64 with RESET_VAL=all-ones → idle output equals all-ones; the streaming scenario passes.
